// File: rtl/restoration_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : restoration_pkg                                        |
// | Description : Shared state encoding and default constants for the   |
// |               restoration-pulse measurement sequencer.              |
// | Revision    : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
package restoration_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_TRIGGER = 3'd3,
    ST_WAIT    = 3'd4,
    ST_REPORT  = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  localparam int DEF_CNT_W         = 16;
  localparam int DEF_TRIG_WIDTH    = 8;
  localparam int DEF_SETTLE_CYCLES = 32;

  // Done stays high from the previous measurement for about this many
  // cycles after a new trigger edge; rising edges inside it are ignored.
  localparam int DONE_BLANK = 3;

endpackage
`default_nettype wire

// File: rtl/restoration_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : restoration_sequencer_if                               |
// | Description : Control, measurement-path and result signals of the   |
// |               restoration sequencer.                                |
// | Revision    : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
interface restoration_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start;
  logic              abort;
  logic [NUM_CH-1:0] ch_mask;
  logic [CNT_W-1:0]  timeout_cycles;
  logic              Pulse_Measurement_Done;
  logic [CH_W-1:0]   ch_sel;
  logic              Pulser_Trigger_Request;
  logic              busy;
  logic              result_valid;
  logic [CH_W-1:0]   result_ch;
  logic [CNT_W-1:0]  result_cycles;
  logic              result_timeout;
  logic              seq_done;

  // Sequencer side
  modport master (
    input  start, abort, ch_mask, timeout_cycles, Pulse_Measurement_Done,
    output ch_sel, Pulser_Trigger_Request, busy, result_valid,
           result_ch, result_cycles, result_timeout, seq_done
  );

  // Host / measurement side
  modport slave (
    output start, abort, ch_mask, timeout_cycles, Pulse_Measurement_Done,
    input  ch_sel, Pulser_Trigger_Request, busy, result_valid,
           result_ch, result_cycles, result_timeout, seq_done
  );
endinterface
`default_nettype wire

// File: rtl/restoration_ch_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : restoration_ch_pick                                    |
// | Description : Finds the lowest enabled channel at or above a start  |
// |               index. idx is one bit wider than a channel number so |
// |               that "past the last channel" is representable.       |
// | Revision    : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
module restoration_ch_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W:0]     idx,
  output logic              found,
  output logic [CH_W-1:0]   ch
);

  // Scan downward so the last hit written is the lowest qualifying bit
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(idx))) begin
        found = 1'b1;
        ch    = CH_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/restoration_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : restoration_sequencer                                  |
// | Description : Scans enabled channels, settles the mux, fires the    |
// |               shared pulser trigger and times the Done response.   |
// |               Optional macro RESTORATION_RETRY_EN: one retry of a  |
// |               channel after its first timeout.                     |
// | Revision    : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
module restoration_sequencer
  import restoration_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TRIG_WIDTH    = DEF_TRIG_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  restoration_sequencer_if.master bus
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            r_state;
  state_t            w_next;
  logic [NUM_CH-1:0] r_mask;
  logic [CNT_W-1:0]  r_timeout;
  logic [CNT_W-1:0]  r_elapsed;
  logic [CNT_W-1:0]  r_settle;
  logic [CH_W:0]     r_idx;
  logic [CH_W-1:0]   r_ch_sel;
  logic [CH_W-1:0]   r_res_ch;
  logic [CNT_W-1:0]  r_res_cycles;
  logic              r_res_timeout;
  logic              r_done_d;
  logic              w_found;
  logic [CH_W-1:0]   w_pick_ch;
  logic              w_edge;
  logic              w_hit;
  logic              w_tmo;
  logic              w_abort;
`ifdef RESTORATION_RETRY_EN
  logic              r_retry;
  logic              w_retry_set;
`endif

  restoration_ch_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .mask  (r_mask),
    .idx   (r_idx),
    .found (w_found),
    .ch    (w_pick_ch)
  );

  // Qualified Done edge: stale-level blanking right after the trigger edge
  assign w_edge  = bus.Pulse_Measurement_Done & ~r_done_d &
                   (r_elapsed > CNT_W'(DONE_BLANK));
  assign w_abort = bus.abort & (r_state != ST_IDLE) & (r_state != ST_FINISH);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; abort overrides any same-cycle Done edge or timeout
  always_comb begin
    w_next = r_state;
    w_hit  = 1'b0;
    w_tmo  = 1'b0;
`ifdef RESTORATION_RETRY_EN
    w_retry_set = 1'b0;
`endif
    case (r_state)
      ST_IDLE:    if (bus.start && !bus.abort) w_next = ST_SELECT;
      ST_SELECT:  w_next = w_found ? ST_SETTLE : ST_FINISH;
      ST_SETTLE:  if (r_settle == CNT_W'(SETTLE_CYCLES - 1)) w_next = ST_TRIGGER;
      ST_TRIGGER: begin
        if (w_edge) begin
          w_next = ST_REPORT;
          w_hit  = 1'b1;
        end else if (r_elapsed == CNT_W'(TRIG_WIDTH - 1)) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_edge) begin
          w_next = ST_REPORT;
          w_hit  = 1'b1;
        end else if (r_elapsed >= r_timeout) begin
`ifdef RESTORATION_RETRY_EN
          if (!r_retry) begin
            w_next      = ST_SETTLE;
            w_retry_set = 1'b1;
          end else begin
            w_next = ST_REPORT;
            w_tmo  = 1'b1;
          end
`else
          w_next = ST_REPORT;
          w_tmo  = 1'b1;
`endif
        end
      end
      ST_REPORT:  w_next = ST_SELECT;
      ST_FINISH:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_FINISH;
      w_hit  = 1'b0;
      w_tmo  = 1'b0;
`ifdef RESTORATION_RETRY_EN
      w_retry_set = 1'b0;
`endif
    end
  end

  // Sequence context, counters and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask        <= '0;
      r_timeout     <= '0;
      r_elapsed     <= '0;
      r_settle      <= '0;
      r_idx         <= '0;
      r_ch_sel      <= '0;
      r_res_ch      <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
      r_done_d      <= 1'b0;
    end else begin
      r_done_d <= bus.Pulse_Measurement_Done;
      if (r_state == ST_IDLE && w_next == ST_SELECT) begin
        r_mask    <= bus.ch_mask;
        r_timeout <= (bus.timeout_cycles == '0) ? '1 : bus.timeout_cycles;
        r_idx     <= '0;
      end
      if (r_state == ST_SELECT && w_found) begin
        r_idx    <= {1'b0, w_pick_ch};
        r_ch_sel <= w_pick_ch;
      end
      if (r_state == ST_REPORT) r_idx <= r_idx + 1'b1;
      r_settle <= (r_state == ST_SETTLE) ? r_settle + 1'b1 : '0;
      // Zero during the first trigger cycle, then counts and saturates
      if (r_state == ST_SETTLE)
        r_elapsed <= '0;
      else if ((r_state == ST_TRIGGER || r_state == ST_WAIT) && r_elapsed != '1)
        r_elapsed <= r_elapsed + 1'b1;
      if (w_hit) begin
        r_res_ch      <= r_ch_sel;
        r_res_cycles  <= r_elapsed;
        r_res_timeout <= 1'b0;
      end else if (w_tmo) begin
        r_res_ch      <= r_ch_sel;
        r_res_cycles  <= r_timeout;
        r_res_timeout <= 1'b1;
      end
    end
  end

`ifdef RESTORATION_RETRY_EN
  // Marks that the current channel has already used its one retry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_retry <= 1'b0;
    else if (r_state == ST_SELECT) r_retry <= 1'b0;
    else if (w_retry_set)          r_retry <= 1'b1;
  end
`endif

  // State decodes reset asynchronously with the state register
  assign bus.Pulser_Trigger_Request = (r_state == ST_TRIGGER);
  assign bus.busy                   = (r_state != ST_IDLE);
  assign bus.result_valid           = (r_state == ST_REPORT);
  assign bus.seq_done               = (r_state == ST_FINISH);
  assign bus.ch_sel                 = r_ch_sel;
  assign bus.result_ch              = r_res_ch;
  assign bus.result_cycles          = r_res_cycles;
  assign bus.result_timeout         = r_res_timeout;

endmodule
`default_nettype wire

// File: tb/tb_restoration_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_restoration_sequencer                               |
// | Description : Randomized scoreboard bench with a Done responder     |
// |               that models the stale Done level after each trigger. |
// | Revision    : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
module tb_restoration_sequencer;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
`ifdef RESTORATION_RETRY_EN
  localparam int TRIES = 2;
`else
  localparam int TRIES = 1;
`endif

  typedef struct {
    bit marker;
    int ch;
    int cycles;
    bit tmo;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t mon_e;
  int   delay_tab [NUM_CH];
  logic [NUM_CH-1:0] cur_mask = '0;
  int   trig_rises = 0;
  int   cyc = 0;
  int   t0 = -100;
  int   pend_d = 0;
  bit   pend = 0;
  bit   prev_trig = 0;

  restoration_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  restoration_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  // Done responder: rises D cycles after the trigger rise (D=0: never),
  // and a level left over from the previous shot clears at trigger+3.
  initial begin
    bus.Pulse_Measurement_Done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        bus.Pulse_Measurement_Done = 1'b0;
        prev_trig = 0;
        pend = 0;
      end else begin
        cyc++;
        if (bus.Pulser_Trigger_Request && !prev_trig) begin
          trig_rises++;
          t0 = cyc;
          pend_d = delay_tab[bus.ch_sel];
          pend = (pend_d != 0);
          check("trigger_ch_enabled", int'(cur_mask[bus.ch_sel]), 1);
        end
        if (cyc == t0 + 3) bus.Pulse_Measurement_Done = 1'b0;
        if (pend && cyc == t0 + pend_d) begin
          bus.Pulse_Measurement_Done = 1'b1;
          pend = 0;
        end
        prev_trig = bus.Pulser_Trigger_Request;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result or end
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.result_valid) begin
        check("result_expected", int'(q.size() > 0 && !q[0].marker), 1);
        if (q.size() > 0 && !q[0].marker) begin
          mon_e = q.pop_front();
          check("result_ch", int'(bus.result_ch), mon_e.ch);
          check("result_cycles", int'(bus.result_cycles), mon_e.cycles);
          check("result_timeout", int'(bus.result_timeout), int'(mon_e.tmo));
        end
      end
      if (bus.seq_done) begin
        check("seq_done_expected", int'(q.size() > 0 && q[0].marker), 1);
        if (q.size() > 0 && q[0].marker) mon_e = q.pop_front();
      end
    end
  end

  // Reference model: one result per enabled channel in ascending order
  task automatic expect_seq(input logic [NUM_CH-1:0] mask, input int tmo,
                            output int n_trig);
    exp_t e;
    int   eff;
    eff = (tmo == 0) ? (1 << CNT_W) - 1 : tmo;
    n_trig = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        e.marker = 0;
        e.ch     = c;
        if (delay_tab[c] != 0 && delay_tab[c] < eff) begin
          e.cycles = delay_tab[c];
          e.tmo    = 0;
          n_trig  += 1;
        end else begin
          e.cycles = eff;
          e.tmo    = 1;
          n_trig  += TRIES;
        end
        q.push_back(e);
      end
    end
    e.marker = 1; e.ch = 0; e.cycles = 0; e.tmo = 0;
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [NUM_CH-1:0] mask, input int tmo);
    cur_mask   = mask;
    trig_rises = 0;
    @(negedge clk);
    bus.ch_mask        = mask;
    bus.timeout_cycles = CNT_W'(tmo);
    bus.start          = 1'b1;
  endtask

  task automatic wait_seq_done(input int budget, input int poke_at, output int took);
    took = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      bus.start = (k == poke_at);
      if (k == 1) begin
        // Inputs are only sampled at start; scramble them afterwards
        bus.ch_mask        = ~cur_mask;
        bus.timeout_cycles = CNT_W'($urandom_range(1, 50));
      end
      if (bus.seq_done) begin
        took = k;
        break;
      end
    end
    bus.start = 1'b0;
    check("seq_done_within_budget", int'(took > 0), 1);
  endtask

  task automatic run_seq(input logic [NUM_CH-1:0] mask, input int tmo, input int poke_at);
    int n_trig;
    int took;
    expect_seq(mask, tmo, n_trig);
    pulse_start(mask, tmo);
    wait_seq_done(6000, poke_at, took);
    @(negedge clk);
    check("busy_low_after_seq", int'(bus.busy), 0);
    check("scoreboard_drained", q.size(), 0);
    check("trigger_count", trig_rises, n_trig);
  endtask

  task automatic randomize_delays(input int tmo);
    for (int c = 0; c < NUM_CH; c++) begin
      delay_tab[c] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 300));
      if (delay_tab[c] == tmo) delay_tab[c]++;
    end
  endtask

  initial begin
    int took;
    int tmo;
    bit seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ch_mask = '0;
    bus.timeout_cycles = '0;
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 0;

    repeat (3) @(negedge clk);
    check("rst_trigger", int'(bus.Pulser_Trigger_Request), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_seq_done", int'(bus.seq_done), 0);
    check("rst_ch_sel", int'(bus.ch_sel), 0);
    check("rst_result_ch", int'(bus.result_ch), 0);
    check("rst_result_cycles", int'(bus.result_cycles), 0);
    check("rst_result_timeout", int'(bus.result_timeout), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two channels, Done after 50 cycles; second shot sees a stale Done
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 50;
    run_seq(4'b0101, 1000, 0);

    // Done never rises: timeout result
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 0;
    run_seq(4'b0010, 200, 0);

    // Empty mask: seq_done two cycles after start, no trigger
    expect_seq(4'b0000, 100, took);
    pulse_start(4'b0000, 100);
    wait_seq_done(20, 0, took);
    check("empty_mask_latency", took, 2);
    check("empty_mask_triggers", trig_rises, 0);
    @(negedge clk);
    check("empty_mask_busy", int'(bus.busy), 0);

    // Abort five cycles into WAIT on the first channel
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 0;
    expect_seq(4'b0000, 1000, took);
    pulse_start(4'b1111, 1000);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = bus.Pulser_Trigger_Request;
    end
    check("abort_trigger_seen", int'(seen), 1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = !bus.Pulser_Trigger_Request;
    end
    check("abort_wait_entered", int'(seen), 1);
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_trigger_low", int'(bus.Pulser_Trigger_Request), 0);
    check("abort_seq_done", int'(bus.seq_done), 1);
    @(negedge clk);
    check("abort_busy_low", int'(bus.busy), 0);
    check("abort_seq_done_single", int'(bus.seq_done), 0);
    check("abort_triggers", trig_rises, 1);
    check("abort_drained", q.size(), 0);

    // Normal run after abort, with a start poked while busy
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 40 + 10 * c;
    run_seq(4'b1111, 500, 40);

    // Randomized sequences
    for (int n = 0; n < 10; n++) begin
      tmo = $urandom_range(20, 300);
      randomize_delays(tmo);
      run_seq(NUM_CH'($urandom_range(1, 15)), tmo, (n % 2 == 0) ? 40 : 0);
    end

    // Asynchronous reset while the trigger is high
    for (int c = 0; c < NUM_CH; c++) delay_tab[c] = 60;
    pulse_start(4'b1111, 500);
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = bus.Pulser_Trigger_Request;
    end
    check("reset_trigger_seen", int'(seen), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_trigger", int'(bus.Pulser_Trigger_Request), 0);
    check("areset_busy", int'(bus.busy), 0);
    check("areset_ch_sel", int'(bus.ch_sel), 0);
    check("areset_result_valid", int'(bus.result_valid), 0);
    check("areset_seq_done", int'(bus.seq_done), 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Post-reset sequence
    tmo = 150;
    randomize_delays(tmo);
    run_seq(4'b1011, tmo, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
